multicycle_adder: RTL and testbench



---
 rtl/multicycle_adder.sv | 139 +++++++++++++
 tb/tb_multicycle_adder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_adder.sv
// Multi-cycle two's-complement adder/subtractor: adds CHUNK bits per clock with a
// registered carry between chunks, valid/ready handshakes on operand and result sides.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("multicycle_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready depends on state only, out_valid holds (with stable data) until out_ready.
  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;

  // Operand registers shift right each chunk, so the active chunk is always the low bits.
  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
  // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out of the XOR.
  assign msb_carry_in = chunk_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        res_d   = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d     = DONE;
          sum_d       = res_d;
          cout_d      = chunk_sum[CHUNK];
          ovf_d       = chunk_sum[CHUNK] ^ msb_carry_in;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: a CHUNK=4 instance and a CHUNK=16 instance share all
// inputs; results are checked against an arithmetic model through an expected queue.
module tb_multicycle_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_ready;

  logic        in_ready_w, out_valid_w, cout_w, ovf_w;
  logic [15:0] sum_w;
  logic [1:0]  st_w;
  logic        in_ready_1, out_valid_1, cout_1, ovf_1;
  logic [15:0] sum_1;
  logic [1:0]  st_1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] exp_q[$];

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w),
    .out_ready(out_ready), .sum(sum_w), .cout(cout_w), .overflow(ovf_w),
    .state_dbg(st_w)
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_1),
    .out_ready(out_ready), .sum(sum_1), .cout(cout_1), .overflow(ovf_1),
    .state_dbg(st_1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {overflow, cout, sum} from integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                        input logic tcin, input logic tsub);
    int ua, ub, us, sa, sb, ss;
    logic c, v;
    logic [15:0] s;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (tsub) begin
      us = ua - ub;
      ss = sa - sb;
      c  = (ua >= ub);
    end else begin
      us = ua + ub + int'(tcin);
      ss = sa + sb + int'(tcin);
      c  = (us > 65535);
    end
    s = 16'(us & 32'hFFFF);
    v = (ss > 32767) || (ss < -32768);
    return {v, c, s};
  endfunction

  // driver: one operation through both DUTs, result held for 'hold' cycles
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tcin, input logic tsub, input int hold);
    int guard, lat, lat1;
    logic busy_ok;
    logic [17:0] exp;
    guard = 0;
    while (!(in_ready_w && in_ready_1) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1;
    exp_q.push_back(model(ta, tbv, tcin, tsub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    n_checks++;
    if (in_ready_w !== 1'b0)
      $display("FAIL accept: in_ready=%b after accept edge, required 0", in_ready_w);
    else n_pass++;
    lat = 0; lat1 = 0; busy_ok = 1'b1;
    if (out_valid_1) lat1 = -1;
    while (!out_valid_w && lat < 40) begin
      if (in_ready_w !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (out_valid_1 && lat1 == 0) lat1 = lat;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (lat != 4) $display("FAIL latency_n4: %0d edges, required 4", lat);
    else n_pass++;
    n_checks++;
    if (lat1 != 1) $display("FAIL latency_n1: %0d edges, required 1", lat1);
    else n_pass++;
    n_checks++;
    if (!busy_ok) $display("FAIL busy_in_ready: in_ready high while running, required 0");
    else n_pass++;
    n_checks++;
    if ({ovf_w, cout_w, sum_w} !== exp)
      $display("FAIL result_n4 a=%h b=%h sub=%b: ovf/cout/sum=%b/%b/%h required %b/%b/%h",
               ta, tbv, tsub, ovf_w, cout_w, sum_w, exp[17], exp[16], exp[15:0]);
    else n_pass++;
    n_checks++;
    if ({out_valid_1, ovf_1, cout_1, sum_1} !== {1'b1, exp})
      $display("FAIL result_n1 a=%h b=%h sub=%b: vld/ovf/cout/sum=%b/%b/%b/%h required 1/%b/%b/%h",
               ta, tbv, tsub, out_valid_1, ovf_1, cout_1, sum_1, exp[17], exp[16], exp[15:0]);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      cin = 1'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (!(out_valid_w === 1'b1 && in_ready_w === 1'b0 && {ovf_w, cout_w, sum_w} === exp
            && out_valid_1 === 1'b1 && {ovf_1, cout_1, sum_1} === exp))
        $display("FAIL backpressure cyc %0d: vld=%b rdy=%b res=%b/%b/%h required 1/0/%b/%b/%h",
                 i, out_valid_w, in_ready_w, ovf_w, cout_w, sum_w, exp[17], exp[16], exp[15:0]);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid_w, in_ready_w, out_valid_1, in_ready_1} !== 4'b0101)
      $display("FAIL handshake: vld/rdy n4=%b/%b n1=%b/%b required 0/1 0/1",
               out_valid_w, in_ready_w, out_valid_1, in_ready_1);
    else n_pass++;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready_w, out_valid_w, sum_w, cout_w, ovf_w} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset_n4: rdy=%b vld=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
               in_ready_w, out_valid_w, sum_w, cout_w, ovf_w);
    else n_pass++;
    n_checks++;
    if ({in_ready_1, out_valid_1, sum_1, cout_1, ovf_1} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset_n1: rdy=%b vld=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
               in_ready_1, out_valid_1, sum_1, cout_1, ovf_1);
    else n_pass++;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready_w, in_ready_1} !== 2'b11)
      $display("FAIL reset_release: in_ready=%b/%b required 1/1", in_ready_w, in_ready_1);
    else n_pass++;
  endtask

  task automatic test_add();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_sub();
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
    run_op(16'h1234, 16'h1234, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
  endtask

  task automatic test_back_to_back();
    run_op(16'hABCD, 16'h1357, 1'b1, 1'b0, 10);
    run_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    n_checks++;
    if ({out_valid_w, sum_w, in_ready_w, out_valid_1, sum_1, in_ready_1}
        !== {1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1})
      $display("FAIL reset_mid: n4 vld/sum/rdy=%b/%h/%b n1=%b/%h/%b required 0/0000/1",
               out_valid_w, sum_w, in_ready_w, out_valid_1, sum_1, in_ready_1);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready_w, out_valid_w, in_ready_1, out_valid_1} !== 4'b1010)
      $display("FAIL reset_mid_release: rdy/vld n4=%b/%b n1=%b/%b required 1/0",
               in_ready_w, out_valid_w, in_ready_1, out_valid_1);
    else n_pass++;
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
